// File: rtl/uart_prog_loader.sv
// 8N1 UART receiver that streams good bytes into sequential instruction-memory
// addresses while Load is high, tracking count, full and framing-error status.
module uart_prog_loader #(
   parameter int Baudrate = 24,
   parameter int ADDR_W   = 5
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic              Load,
   input  logic              RX,
   output logic              Wr_en,
   output logic [ADDR_W-1:0] Wr_addr,
   output logic [7:0]        Wr_data,
   output logic [ADDR_W:0]   Count,
   output logic              Full,
   output logic              Done,
   output logic              FE
);

   localparam int             BW        = $clog2(Baudrate);
   localparam logic [BW-1:0]  HALF_LAST = BW'(Baudrate / 2 - 1);
   localparam logic [BW-1:0]  BIT_LAST  = BW'(Baudrate - 1);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t              r_state;
   state_t              w_state_nxt;
   logic                r_rx_meta;
   logic                r_rxs;
   logic                r_load_d;
   logic [BW-1:0]       r_baud;
   logic [2:0]          r_bit;
   logic [7:0]          r_shift;
   logic [ADDR_W-1:0]   r_addr;
   logic [ADDR_W:0]     r_count;
   logic                r_full;
   logic                r_fe;
   logic                r_done;
   logic                r_wr_en;
   logic [ADDR_W-1:0]   r_wr_addr;
   logic [7:0]          r_wr_data;
   logic                w_half;
   logic                w_bit_end;
   logic                w_shift;
   logic                w_stop_smp;
   logic                w_load_rise;

   assign w_half      = (r_baud == HALF_LAST);
   assign w_bit_end   = (r_baud == BIT_LAST);
   assign w_load_rise = Load & ~r_load_d;

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         r_rx_meta <= 1'b1;
         r_rxs     <= 1'b1;
         r_load_d  <= 1'b0;
         r_state   <= IDLE;
      end else begin
         r_rx_meta <= RX;
         r_rxs     <= r_rx_meta;
         r_load_d  <= Load;
         r_state   <= w_state_nxt;
      end
   end

   // Dropping Load overrides every transition so a partial frame is abandoned.
   always_comb begin
      w_state_nxt = r_state;
      w_shift     = 1'b0;
      w_stop_smp  = 1'b0;
      case (r_state)
         IDLE:  if (!r_rxs) w_state_nxt = START;
         START: if (w_half) w_state_nxt = r_rxs ? IDLE : DATA;
         DATA:  if (w_bit_end) begin
                   w_shift = 1'b1;
                   if (r_bit == 3'd7) w_state_nxt = STOP;
                end
         STOP:  if (w_bit_end) begin
                   w_stop_smp  = 1'b1;
                   w_state_nxt = IDLE;
                end
         default: w_state_nxt = IDLE;
      endcase
      if (!Load) begin
         w_state_nxt = IDLE;
         w_shift     = 1'b0;
         w_stop_smp  = 1'b0;
      end
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         r_baud <= '0;
         r_bit  <= '0;
      end else begin
         if (r_state == IDLE || w_state_nxt != r_state || w_shift)
            r_baud <= '0;
         else
            r_baud <= r_baud + 1'b1;
         if (r_state == START)
            r_bit <= '0;
         else if (w_shift)
            r_bit <= r_bit + 1'b1;
      end
   end

   always_ff @(posedge Clk) begin
      if (w_shift) r_shift <= {r_rxs, r_shift[7:1]};
   end

   // Strobe fires the cycle after a good stop sample; bookkeeping follows a cycle later.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         r_wr_en   <= 1'b0;
         r_wr_addr <= '0;
         r_wr_data <= '0;
         r_addr    <= '0;
         r_count   <= '0;
         r_full    <= 1'b0;
         r_fe      <= 1'b0;
         r_done    <= 1'b0;
      end else begin
         r_done  <= r_load_d & ~Load;
         r_wr_en <= w_stop_smp & r_rxs & ~r_full;
         if (w_stop_smp && r_rxs && !r_full) begin
            r_wr_addr <= r_addr;
            r_wr_data <= r_shift;
         end
         if (w_load_rise) begin
            r_addr  <= '0;
            r_count <= '0;
            r_full  <= 1'b0;
            r_fe    <= 1'b0;
         end else begin
            if (r_wr_en) begin
               r_count <= r_count + 1'b1;
               if (r_addr == {ADDR_W{1'b1}})
                  r_full <= 1'b1;
               else
                  r_addr <= r_addr + 1'b1;
            end
            if (w_stop_smp && !r_rxs) r_fe <= 1'b1;
         end
      end
   end

   assign Wr_en   = r_wr_en;
   assign Wr_addr = r_wr_addr;
   assign Wr_data = r_wr_data;
   assign Count   = r_count;
   assign Full    = r_full;
   assign Done    = r_done;
   assign FE      = r_fe;

endmodule
